// File: rtl/edge_event_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : edge_event_arbiter                                                |
// | Purpose  : per-channel rising-edge detection with pending flags, serialised  |
// |            onto one valid/ready event port by a round-robin arbiter.         |
// | Option   : define EDGE_ARB_OVF_EN to add sticky per-channel overflow flags.  |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    level_i,
  input  logic            evt_ready_i,
  output logic            evt_valid_o,
  output logic [ID_W-1:0] evt_id_o,
  output logic [N-1:0]    pending_o
`ifdef EDGE_ARB_OVF_EN
  ,
  output logic [N-1:0]    ovf_o
`endif
);

  typedef enum logic [1:0] {
    DET_ZERO = 2'd0,
    DET_EDG  = 2'd1,
    DET_ONE  = 2'd2
  } det_state_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  localparam logic [ID_W-1:0] c_LAST_RST = ID_W'(N - 1);

  logic [N-1:0]    w_tick;
  logic [N-1:0]    w_hs;
  logic [N-1:0]    pending_q;
  logic [N-1:0]    pending_d;
  arb_state_e      arb_q;
  logic            evt_valid_q;
  logic [ID_W-1:0] evt_id_q;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] w_sel_id;
  int              w_best_dist;

  for (genvar gi = 0; gi < N; gi++) begin : g_det
    det_state_e det_q;
    det_state_e det_d;

    always_comb begin
      det_d = DET_ZERO;
      case (det_q)
        DET_ZERO:         det_d = level_i[gi] ? DET_EDG : DET_ZERO;
        DET_EDG, DET_ONE: det_d = level_i[gi] ? DET_ONE : DET_ZERO;
        default:          det_d = DET_ZERO;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        det_q <= DET_ZERO;
      end else begin
        det_q <= det_d;
      end
    end

    assign w_tick[gi] = (det_q == DET_EDG);
    assign w_hs[gi]   = evt_valid_q & evt_ready_i & (evt_id_q == ID_W'(gi));
  end

  // A fresh tick outranks the clear so an edge landing on the handshake is kept.
  assign pending_d = w_tick | (pending_q & ~w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Distance 0 is the channel just after last_q; the nearest pending one wins.
  always_comb begin
    w_sel_id    = '0;
    w_best_dist = N;
    for (int j = 0; j < N; j++) begin
      if (pending_q[j] && (((j + N - 1 - int'(last_q)) % N) < w_best_dist)) begin
        w_best_dist = (j + N - 1 - int'(last_q)) % N;
        w_sel_id    = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_q       <= ARB_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      last_q      <= c_LAST_RST;
    end else begin
      case (arb_q)
        ARB_IDLE: begin
          if (|pending_q) begin
            evt_id_q    <= w_sel_id;
            evt_valid_q <= 1'b1;
            arb_q       <= ARB_OFFER;
          end
        end
        ARB_OFFER: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            last_q      <= evt_id_q;
            arb_q       <= ARB_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          arb_q       <= ARB_IDLE;
        end
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign pending_o   = pending_q;

`ifdef EDGE_ARB_OVF_EN
  logic [N-1:0] ovf_q;
  logic [N-1:0] ovf_d;

  assign ovf_d = ovf_q | (w_tick & pending_q & ~w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_edge_event_arbiter                                             |
// | Purpose  : scenario tasks plus an id scoreboard for edge_event_arbiter.      |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    level = '0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic [N-1:0]    pending;
`ifdef EDGE_ARB_OVF_EN
  logic [N-1:0]    ovf;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [ID_W-1:0] exp_q[$];
  logic [ID_W-1:0] exp_id;

  edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .level_i     (level),
    .evt_ready_i (evt_ready),
    .evt_valid_o (evt_valid),
    .evt_id_o    (evt_id),
    .pending_o   (pending)
`ifdef EDGE_ARB_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake is decided at the next rising edge, sampled just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst && evt_valid && evt_ready) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL evt_unexpected: got id %0d, expected no event", evt_id);
      end else begin
        exp_id = exp_q.pop_front();
        if (evt_id !== exp_id) $display("FAIL evt_id_order: got %0d, expected %0d", evt_id, exp_id);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; level = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", evt_valid); else pass_cnt++;
    chk_cnt++; if (evt_id !== 2'd0) $display("FAIL reset_id: got %0d, expected 0", evt_id); else pass_cnt++;
    chk_cnt++; if (pending !== 4'b0000) $display("FAIL reset_pending: got %b, expected 0000", pending); else pass_cnt++;
`ifdef EDGE_ARB_OVF_EN
    chk_cnt++; if (ovf !== 4'b0000) $display("FAIL reset_ovf: got %b, expected 0000", ovf); else pass_cnt++;
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b0) $display("FAIL post_reset_valid: got %b, expected 0", evt_valid); else pass_cnt++;
  endtask

  task automatic test_single_event();
    int extra;
    level = 4'b0001; evt_ready = 1'b1; exp_q.push_back(2'd0);
    @(negedge clk);
    chk_cnt++; if (pending !== 4'b0000) $display("FAIL single_t0_pending: got %b, expected 0000", pending); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (pending !== 4'b0001) $display("FAIL single_t1_pending: got %b, expected 0001", pending); else pass_cnt++;
    chk_cnt++; if (evt_valid !== 1'b0) $display("FAIL single_t1_valid: got %b, expected 0", evt_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) $display("FAIL single_t2_offer: got valid %b id %0d, expected valid 1 id 0", evt_valid, evt_id); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL single_t3_done: got valid %b pending %b, expected 0 and 0000", evt_valid, pending); else pass_cnt++;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) extra++;
    end
    chk_cnt++; if (extra != 0) $display("FAIL single_held_level: got %0d extra valid cycles, expected 0", extra); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL single_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit stable;
    evt_ready = 1'b0; level = 4'b0100; exp_q.push_back(2'd2);
    repeat (3) @(negedge clk);
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (evt_valid !== 1'b1 || evt_id !== 2'd2) stable = 1'b0;
    end
    chk_cnt++; if (!stable) $display("FAIL bp_stable: got unstable offer (last valid %b id %0d), expected valid 1 id 2 for 6 cycles", evt_valid, evt_id); else pass_cnt++;
    chk_cnt++; if (pending[2] !== 1'b1) $display("FAIL bp_pending_held: got %b, expected 1", pending[2]); else pass_cnt++;
    evt_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b0 || pending[2] !== 1'b0) $display("FAIL bp_release: got valid %b pending2 %b, expected 0 and 0", evt_valid, pending[2]); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] pat;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    level = 4'b1111; evt_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      pat[7-k] = evt_valid;
    end
    chk_cnt++; if (pat !== 8'b10101010) $display("FAIL rr_bubble: got valid pattern %b, expected 10101010", pat); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rr_burst1_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0; repeat (3) @(negedge clk);
    level = 4'b0010; exp_q.push_back(2'd1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rr_ch1_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0; repeat (3) @(negedge clk);
    level = 4'b1111;
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rr_burst2_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_set_clear();
    evt_ready = 1'b0; level = 4'b0010; exp_q.push_back(2'd1);
    repeat (3) @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) $display("FAIL sc_offer: got valid %b id %0d, expected valid 1 id 1", evt_valid, evt_id); else pass_cnt++;
    level = 4'b0000;
    @(negedge clk);
    level = 4'b0010; exp_q.push_back(2'd1);
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b0 || pending[1] !== 1'b1) $display("FAIL sc_set_wins: got valid %b pending1 %b, expected 0 and 1", evt_valid, pending[1]); else pass_cnt++;
`ifdef EDGE_ARB_OVF_EN
    chk_cnt++; if (ovf[1] !== 1'b0) $display("FAIL sc_no_ovf: got %b, expected 0", ovf[1]); else pass_cnt++;
`endif
    @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) $display("FAIL sc_reoffer: got valid %b id %0d, expected valid 1 id 1", evt_valid, evt_id); else pass_cnt++;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL sc_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    chk_cnt++; if (pending !== 4'b0000) $display("FAIL sc_pending_clear: got %b, expected 0000", pending); else pass_cnt++;
    level = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_merge_overflow();
    int extra;
    evt_ready = 1'b0; level = 4'b1000; exp_q.push_back(2'd3);
    @(negedge clk); level = 4'b0000;
    @(negedge clk); level = 4'b1000;
    repeat (3) @(negedge clk);
    chk_cnt++; if (pending !== 4'b1000) $display("FAIL merge_pending: got %b, expected 1000", pending); else pass_cnt++;
    chk_cnt++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) $display("FAIL merge_offer: got valid %b id %0d, expected valid 1 id 3", evt_valid, evt_id); else pass_cnt++;
`ifdef EDGE_ARB_OVF_EN
    chk_cnt++; if (ovf !== 4'b1000) $display("FAIL ovf_set: got %b, expected 1000", ovf); else pass_cnt++;
`endif
    evt_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL merge_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) extra++;
    end
    chk_cnt++; if (extra != 0) $display("FAIL merge_single_delivery: got %0d extra valid cycles, expected 0", extra); else pass_cnt++;
`ifdef EDGE_ARB_OVF_EN
    chk_cnt++; if (ovf !== 4'b1000) $display("FAIL ovf_sticky: got %b, expected 1000", ovf); else pass_cnt++;
`endif
    level = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_offer();
    evt_ready = 1'b1; level = 4'b0010; exp_q.push_back(2'd1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rmo_prep_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    level = 4'b0100;
    repeat (3) @(negedge clk);
    chk_cnt++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) $display("FAIL rmo_offer: got valid %b id %0d, expected valid 1 id 2", evt_valid, evt_id); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (evt_valid !== 1'b0 || evt_id !== 2'd0 || pending !== 4'b0000) $display("FAIL rmo_async: got valid %b id %0d pending %b, expected 0 0 0000", evt_valid, evt_id, pending); else pass_cnt++;
`ifdef EDGE_ARB_OVF_EN
    chk_cnt++; if (ovf !== 4'b0000) $display("FAIL rmo_ovf_clear: got %b, expected 0000", ovf); else pass_cnt++;
`endif
    level = 4'b0101; evt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rmo_priority_drain: got %0d outstanding, expected 0", exp_q.size()); else pass_cnt++;
    level = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_backpressure();
    test_round_robin();
    test_set_clear();
    test_merge_overflow();
    test_reset_mid_offer();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event collector and round-robin scheduler.
- Each of N level inputs gets its own three-state Moore edge detector (ZERO/EDG/ONE) and a pending flag.
- A round-robin arbiter serialises the pending events onto one valid/ready event port, tagged with a channel id.
- Sits between raw level sources (switches, sync'd strobes) and a single shared event consumer.

Parameters:
- N, 4, number of level channels (2..16).
- ID_W, 2, width of evt_id; must satisfy 2**ID_W >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- level  input  N  per-channel level inputs, already synchronous to clk.
- evt_ready  input  1  consumer accepts the offered event.
- evt_valid  output  1  event offered on evt_id.
- evt_id  output  ID_W  channel index of the offered event.
- pending  output  N  per-channel pending-event flags (registered).
- ovf  output  N  sticky per-channel overflow flags; present only with EDGE_ARB_OVF_EN.

Behaviour:
- Reset (async, active-high):
  - all detectors go to ZERO; pending=0; evt_valid=0; evt_id=0; ovf=0.
  - arbiter goes to IDLE; round-robin pointer last=N-1, so channel 0 has first priority.
  - Asserting rst mid-offer drops evt_valid immediately; the event is discarded.
- Detector per channel, Moore, registered:
  - ZERO -> EDG if level[i]=1, else stay in ZERO.
  - EDG -> ONE if level[i]=1, else -> ZERO.
  - ONE -> ONE if level[i]=1, else -> ZERO.
  - tick[i] = (state==EDG); it is an internal signal, high for exactly one cycle per rising level.
  - A 1-cycle level pulse still produces a tick.
  - level held high produces only one tick.
- Pending:
  - On a clock edge with tick[i]=1, pending[i] is set.
  - On a clock edge with a handshake on channel i (evt_valid & evt_ready & evt_id==i), pending[i] is cleared.
  - If tick[i] and a handshake on i occur on the same edge, set wins: pending[i] stays 1, because a new event has arrived.
  - If tick[i] arrives while pending[i] is already 1, the events merge (one delivery).
- Arbiter FSM:
  - IDLE:
    - if pending != 0, select the first set bit searching last+1, last+2, ... modulo N.
    - Register that index into evt_id, set evt_valid=1, go to OFFER.
    - Otherwise stay in IDLE with evt_valid=0.
  - OFFER:
    - evt_valid and evt_id are held stable until evt_ready=1.
    - On the handshake edge: clear pending[evt_id], set last=evt_id, set evt_valid=0, go to IDLE.
    - evt_ready while evt_valid=0 is ignored.
  - Throughput is at most one event per 2 cycles; the IDLE bubble is mandatory.
- Latency:
  - level[i] is first sampled high at edge T0; tick is high in the cycle after T0.
  - pending[i] is set at T1; evt_valid rises at T2 when the arbiter is idle.
- Fairness: with all N channels continuously pending, each channel is granted exactly once every N handshakes.
- evt_id arithmetic: the pointer wraps from N-1 to 0; ids >= N are never produced.

Optional Feature:
- Macro: EDGE_ARB_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf[i] is set on an edge where tick[i]=1 and pending[i]=1, unless that same edge carries the handshake for i.
  - ovf is sticky until rst.
- Undefined: no ovf port and no overflow logic; merged events are silently lost.

Test Plan:
- Single event:
  - Stimulus: rst for 2 cycles, then level=4'b0001 held, evt_ready=1.
  - Response: tick0 for one cycle; pending[0] at T1; evt_valid=1 with evt_id=0 after T2 for exactly 1 cycle.
  - No further events while level stays high.
- Back-pressure:
  - Stimulus: level[2] rises, evt_ready=0 for 5 cycles, then 1.
  - Response: evt_valid=1 and evt_id=2 stable for 6 cycles; pending[2] clears on the handshake edge.
- Round-robin:
  - Stimulus: all four levels rise on the same cycle, evt_ready=1.
  - Response: ids delivered in order 0,1,2,3, with evt_valid high every other cycle.
  - A second burst after the last grant to channel 1 is served in order 2,3,0,1.
- Simultaneous set/clear:
  - Stimulus: a new rising edge on channel 1 timed so that tick1 coincides with the handshake of id 1.
  - Response: pending[1] remains 1 and a second id 1 event is offered.
- Overflow (EDGE_ARB_OVF_EN):
  - Stimulus: level[3] pulses 0-1-0-1 while evt_ready=0.
  - Response: pending[3]=1 and ovf[3]=1; only one id 3 is delivered when ready is released; ovf[3] stays 1 until rst.
- Reset mid-offer:
  - Stimulus: rst asserted while evt_valid=1.
  - Response: evt_valid, pending and evt_id go to 0 asynchronously; after release, channel 0 has first priority.
